detect_template_writer: RTL
===========================

Name: detect_template_writer

Overview:
- Capture side of the 26x26 detection template store: the template memory is read by address with 1-cycle registered data; this block fills it.
- Watches the raster pixel stream and cuts a TMPL_W x TMPL_H window at a programmable origin.
- Binarises each window pixel against a threshold and issues sequential memory writes with raster address 0..675.
- Writes land in the same 0/255 byte format the detector reads back.

Parameters:
- TMPL_W, 26, template width in pixels.
- TMPL_H, 26, template height in pixels.
- IMG_W, 320, active frame width in pixels.
- IMG_H, 240, active frame height in lines.
- ADDR_W, 10, template address width; must satisfy 2^ADDR_W >= TMPL_W*TMPL_H.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle capture request; sampled only in IDLE.
- roi_x  in  10  window left column; latched on accepted start.
- roi_y  in  10  window top line; latched on accepted start.
- threshold  in  8  binarisation level; latched on accepted start.
- pix_valid  in  1  pix_data, sof and eol are qualified by this.
- pix_data  in  8  grey pixel.
- sof  in  1  first pixel of frame; valid only with pix_valid.
- eol  in  1  last pixel of line; valid only with pix_valid.
- wr_en  out  1  template write strobe.
- wr_addr  out  ADDR_W  template write address.
- wr_data  out  8  255 or 0.
- busy  out  1  high in ARMED and CAPTURE.
- done  out  1  one-cycle pulse after the final write.
- error  out  1  one-cycle pulse on rejected start or aborted capture.

Behaviour:
- Reset: state=IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0; col, row and write counters cleared. Reset mid-capture abandons the capture without a done or error pulse; memory contents already written are left as is.
- FSM states: IDLE, ARMED, CAPTURE, DONE.
- IDLE, start=1:
  - If roi_x > IMG_W-TMPL_W or roi_y > IMG_H-TMPL_H: pulse error next cycle, stay IDLE.
  - Otherwise latch roi_x, roi_y and threshold, then go to ARMED.
- ARMED: wait for pix_valid&sof. That pixel is (col=0,row=0) and is processed in the same cycle. Go to CAPTURE.
- Position tracking in ARMED/CAPTURE, for each pix_valid beat:
  - eol=1: col<=0, row<=row+1.
  - Else: col<=col+1.
  - sof forces col and row back to the origin for that pixel.
- Window hit: roi_x<=col<roi_x+TMPL_W and roi_y<=row<roi_y+TMPL_H, evaluated on the current pixel's coordinates.
- On a hit, next cycle:
  - wr_en=1.
  - wr_addr = write counter.
  - wr_data = 255 if pix_data>=threshold (unsigned), else 0.
  - Counter then increments.
- Latency: 1 cycle from the hit beat to wr_en. Raster order gives consecutive addresses with no multiplier; wr_addr is held when wr_en=0.
- After the write of address TMPL_W*TMPL_H-1, state goes to DONE. DONE pulses done for one cycle, then goes to IDLE. Stream beats arriving in DONE/IDLE are ignored.
- Abort: sof with pix_valid while in CAPTURE and counter < TMPL_W*TMPL_H (truncated frame) causes:
  - error pulse;
  - return to IDLE;
  - counter reset.
  - That sof is not used to restart.
- pix_valid=0 cycles: counters hold, no write. Gaps inside the window are legal.
- start in any non-IDLE state: ignored.
- The same cycle as done may carry start? No: done is issued in DONE, so start is only accepted one cycle later in IDLE.
- Threshold edges:
  - threshold=0 makes every pixel 255.
  - threshold=255 makes only pix_data=255 give 255.
- busy deasserts in the cycle done is high.

Test Plan:
- Nominal capture: roi=(10,5), threshold=128, 320x240 frame with pix=(col+row)&255.
  - Required: exactly 676 writes, addresses 0..675 in order.
  - First write carries pixel (10,5) → 255 iff 15>=128 → 0.
  - done pulses once, 1 cycle after the addr-675 write.
- Edge ROI accepted: roi=(294,214) is accepted, last write addr 675 from pixel (319,239). roi=(295,0) gives error pulse, state stays IDLE, no wr_en.
- Stalled stream: pix_valid toggling 1/0 randomly gives the identical write sequence as the nominal case. Each wr_en follows its valid hit by exactly 1 cycle.
- Truncated frame: new sof after 300 window writes.
  - Required: error pulse, no done, return to IDLE.
  - A subsequent start plus a full frame completes normally from addr 0.
- Reset mid-capture: reset asserted after write 100.
  - Next cycle: all outputs 0, state IDLE.
  - No done or error pulse.
- Threshold extremes: threshold=0 gives all wr_data=255. threshold=255 with constant pix 254 gives all 0.

Source files
------------

// File: rtl/detect_template_writer.sv
// Capture side of the detection template store. Watches the raster pixel
// stream, cuts a TMPL_W x TMPL_H window at a programmable origin, binarises
// each window pixel against a threshold and writes it as 0/255 to
// sequential template addresses 0..TMPL_W*TMPL_H-1.
module detect_template_writer #(
   parameter int TMPL_W = 26,
   parameter int TMPL_H = 26,
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int ADDR_W = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [9:0]        roi_x,
   input  logic [9:0]        roi_y,
   input  logic [7:0]        threshold,
   input  logic              pix_valid,
   input  logic [7:0]        pix_data,
   input  logic              sof,
   input  logic              eol,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   // One extra bit so the write counter can hold the full template size
   // even when it equals 2^ADDR_W.
   localparam int                CNT_W     = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  TOTAL_C   = CNT_W'(TMPL_W * TMPL_H);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TMPL_W * TMPL_H - 1);
   localparam logic [9:0]        MAX_X     = 10'(IMG_W - TMPL_W);
   localparam logic [9:0]        MAX_Y     = 10'(IMG_H - TMPL_H);

   logic [1:0]       state;
   logic [9:0]       roi_x_q;
   logic [9:0]       roi_y_q;
   logic [7:0]       thr_q;
   logic [9:0]       col;
   logic [9:0]       row;
   logic [CNT_W-1:0] wcnt;

   logic [9:0] col_e;
   logic [9:0] row_e;
   logic       start_ok;
   logic       abort;
   logic       beat;
   logic       in_win;
   logic       hit;

   assign busy = (state == S_ARMED) || (state == S_CAPTURE);

   // Current pixel coordinates, window test and beat qualification.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      col_e    = sof ? 10'd0 : col;
      row_e    = sof ? 10'd0 : row;
      start_ok = (roi_x <= MAX_X) && (roi_y <= MAX_Y);
      abort    = (state == S_CAPTURE) && pix_valid && sof && (wcnt < TOTAL_C);
      beat     = pix_valid && (((state == S_ARMED) && sof) ||
                               ((state == S_CAPTURE) && !abort));
      in_win   = ({1'b0, col_e} >= {1'b0, roi_x_q}) &&
                 ({1'b0, col_e} <  ({1'b0, roi_x_q} + 11'(TMPL_W))) &&
                 ({1'b0, row_e} >= {1'b0, roi_y_q}) &&
                 ({1'b0, row_e} <  ({1'b0, roi_y_q} + 11'(TMPL_H)));
      hit      = beat && in_win && (wcnt < TOTAL_C);
   end

   // Control FSM: start acceptance, abort on truncated frame, completion.
   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
         state   <= S_IDLE;
         roi_x_q <= '0;
         roi_y_q <= '0;
         thr_q   <= '0;
         wcnt    <= '0;
         done    <= 1'b0;
         error   <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (start_ok) begin
                     roi_x_q <= roi_x;
                     roi_y_q <= roi_y;
                     thr_q   <= threshold;
                     wcnt    <= '0;
                     state   <= S_ARMED;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
            S_ARMED: begin
               if (pix_valid && sof) state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               if (abort) begin
                  error <= 1'b1;
                  wcnt  <= '0;
                  state <= S_IDLE;
               end else if (wr_en && (wr_addr == LAST_ADDR)) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         if (hit) wcnt <= wcnt + CNT_W'(1);
      end
   end

   // Raster position tracking; sof re-anchors the origin for its own pixel.
   always_ff @(posedge clock) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (beat) begin
         if (eol) begin
            col <= '0;
            row <= row_e + 10'd1;
         end else begin
            col <= col_e + 10'd1;
            row <= row_e;
         end
      end
   end

   // Template write port, one cycle behind the hit; address and data hold between writes.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= hit;
         if (hit) begin
            wr_addr <= wcnt[ADDR_W-1:0];
            wr_data <= (pix_data >= thr_q) ? 8'hFF : 8'h00;
         end
      end
   end

endmodule
